i2c_slave_fsm: RTL
==================

Name: i2c_slave_fsm

Overview:
- I2C target (responder) block; the other end of the bus from the team's I2C master FSM.
- Samples scl/sda with the system clock (source_clk, oversampled, no SCL-domain logic).
- Detects START/STOP, matches a 7-bit address, receives write bytes and serves read bytes over a simple byte handshake.
- Used as an on-board loopback target and as a bench model for the master, and sits behind the pad-level open-drain buffers.

Parameters:
- SLAVE_ADDR, 7'h53, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (min 2).

Ports:
- source_clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- scl_in  input  1  raw SCL pad value.
- sda_in  input  1  raw SDA pad value.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Top level: sda = sda_oe ? 1'b0 : 1'bz.
- scl_oe  output  1  1 = hold SCL low (clock stretch); constant 0 when the optional feature is compiled out.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- rx_ready  input  1  1 = ACK write bytes; 0 = NACK write bytes.
- tx_data  input  8  next byte to send for a read.
- tx_valid  input  1  tx_data is valid; used only with the optional feature.
- tx_req  output  1  one-cycle pulse; supply next read byte.
- tx_nack  output  1  one-cycle pulse; master NACKed a read byte.
- addressed  output  1  high from address match until STOP or repeated START.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0, rx_data=8'h00, state IDLE, bit counter 0, sync chains loaded with 1.
- Synchronisation: SYNC_STAGES-deep chains give scl_s/sda_s; one further register gives the previous values.
  - scl_rise / scl_fall are detected from the synced value vs. its previous value.
  - START = sda_s falls while scl_s=1. STOP = sda_s rises while scl_s=1.
  - Total detection latency SYNC_STAGES+1 cycles after the pad change.
- Precedence: rst > STOP > START > SCL edges.
  - STOP in any state: go to IDLE, sda_oe=0, addressed=0.
  - START in any state (including repeated START): go to ADDR, bit counter cleared, sda_oe=0.
- SDA is only changed on a detected scl_fall. Master SDA is only sampled on scl_rise.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on scl_rise (7 address bits + R/W). After the 8th rise:
    - match: go to ADDR_ACK.
    - mismatch: go to WAIT_STOP, SDA never driven.
  - ADDR_ACK:
    - next scl_fall: sda_oe=1, addressed=1.
    - If R/W=1, pulse tx_req on that same fall.
    - Following scl_fall (end of 9th clock): if W, release SDA and go to WR_DATA. If R, load tx_data into the shift register, drive its MSB (sda_oe = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On the 8th rise: rx_data updated, rx_valid pulses the same cycle, sample rx_ready, go to WR_ACK.
  - WR_ACK:
    - next scl_fall: sda_oe = rx_ready.
    - following scl_fall: release SDA, return to WR_DATA.
  - RD_DATA: on each scl_fall drive the next bit. After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): pulse tx_req, then on the next scl_fall load tx_data and drive its MSB; go to RD_DATA.
    - 1 (NACK): pulse tx_nack, go to WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- Bit counter: 3-bit, wraps 7→0 at each byte boundary, cleared on START.
- rx_ready / tx_data must be stable from the request pulse to the next scl_fall. Without stretching the target does not wait.
- rx_valid, tx_req, tx_nack: never high for more than one cycle; never high in IDLE or WAIT_STOP.

Optional Feature:
- Macro I2C_SLAVE_CLK_STRETCH_EN.
- Defined: in ADDR_ACK (read) and RD_ACK-after-ACK, if tx_valid=0 at the loading scl_fall:
  - scl_oe=1 holds SCL low and the load is deferred.
  - When tx_valid=1: load tx_data, drive MSB, wait 1 cycle, then scl_oe=0.
  - STOP/START/rst clear scl_oe immediately.
- Undefined: scl_oe tied 0, tx_valid ignored, tx_data loaded unconditionally.

Test Plan:
- Write 0x53/W, data 0xA5, 0x3C, rx_ready=1, STOP → ACK on all 3 bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; addressed 1→0 at STOP.
- Address 0x52/W → no ACK (SDA stays 1 at 9th clock); no rx_valid; addressed stays 0; next START+0x53 is ACKed.
- Read 0x53/R, tx_data 0x96 then 0x0F, master ACKs byte 1 and NACKs byte 2 → SDA shows 1001_0110 then 0000_1111; tx_req pulses 2×; tx_nack pulses once.
- Write with rx_ready=0 → SDA=1 at the data ACK slot; rx_data still updated to the written byte.
- Repeated START after one write byte, then 0x53/R → state returns to ADDR; read proceeds correctly; no STOP needed in between.
- With I2C_SLAVE_CLK_STRETCH_EN, tx_valid held 0 for 20 cycles on read → scl_oe=1 for ≥20 cycles; after tx_valid=1 the correct MSB is on SDA before scl_oe drops. Also: rst asserted mid-byte → all outputs 0 on the next edge.

Source files
------------

// File: rtl/i2c_slave_fsm.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte rx/tx handshake.
// Define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low while a read byte is not yet available.
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h53,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       source_clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       tx_nack,
    output logic       addressed
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       addressed_q, addressed_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       ack_q, ack_d;
    logic [7:0] byte_in;
    logic       load_req, load_now;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    // Byte completed by the bit arriving this cycle; only 7 bits need to be stored.
    assign byte_in   = {shift_q, sda_s};

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic scl_oe_q, scl_oe_d;
    logic stretch_q, stretch_d;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
`endif

    always_ff @(posedge source_clk) begin
        // NOTE: reset is synchronous; sync chains reload to the idle-bus level 1 so no false edge follows reset.
        if (rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rx_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            ack_q       <= ack_d;
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    always_ff @(posedge source_clk) begin
        if (rst) begin
            scl_oe_q  <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            scl_oe_q  <= scl_oe_d;
            stretch_q <= stretch_d;
        end
    end
    assign scl_oe = scl_oe_q;
`else
    assign scl_oe = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        ack_d       = ack_q;
        rx_valid    = 1'b0;
        tx_req      = 1'b0;
        tx_nack     = 1'b0;
        load_req    = 1'b0;
        load_now    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        scl_oe_d    = scl_oe_q;
        stretch_d   = stretch_q;
`endif

        case (state_q)
            ADDR: if (scl_rise) begin
                shift_d   = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (byte_in[7:1] == SLAVE_ADDR) begin
                        rw_d    = byte_in[0];
                        phase_d = 1'b0;
                        state_d = ADDR_ACK;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            // phase_q: 0 = ACK slot not yet opened, 1 = ACK driven, waiting for end of 9th clock
            ADDR_ACK: if (scl_fall) begin
                if (!phase_q) begin
                    sda_oe_d    = 1'b1;
                    addressed_d = 1'b1;
                    tx_req      = rw_q;
                    phase_d     = 1'b1;
                end else if (rw_q) begin
                    load_req = 1'b1;
                end else begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    phase_d   = 1'b0;
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: if (scl_rise) begin
                shift_d   = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d = byte_in;
                    rx_valid  = 1'b1;
                    ack_d     = rx_ready;
                    phase_d   = 1'b0;
                    state_d   = WR_ACK;
                end
            end
            WR_ACK: if (scl_fall) begin
                if (!phase_q) begin
                    sda_oe_d = ack_q;
                    phase_d  = 1'b1;
                end else begin
                    sda_oe_d = 1'b0;
                    phase_d  = 1'b0;
                    state_d  = WR_DATA;
                end
            end
            RD_DATA: if (scl_fall) begin
                if (bit_cnt_q == 3'd7) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    phase_d   = 1'b0;
                    state_d   = RD_ACK;
                end else begin
                    sda_oe_d  = ~shift_q[6];
                    shift_d   = {shift_q[5:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            RD_ACK: begin
                if (!phase_q && scl_rise) begin
                    if (sda_s) begin
                        tx_nack = 1'b1;
                        state_d = WAIT_STOP;
                    end else begin
                        tx_req  = 1'b1;
                        phase_d = 1'b1;
                    end
                end else if (phase_q && scl_fall) begin
                    load_req = 1'b1;
                end
            end
            default: ;
        endcase

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // A deferred load keeps SCL low one extra cycle so the MSB settles before release.
        load_now = stretch_q ? tx_valid : (load_req & tx_valid);
        if (load_req && !tx_valid) begin
            scl_oe_d  = 1'b1;
            stretch_d = 1'b1;
        end
        if (load_now) stretch_d = 1'b0;
        if (state_q == RD_DATA) scl_oe_d = 1'b0;
`else
        load_now = load_req;
`endif

        if (load_now) begin
            shift_d   = tx_data[6:0];
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = RD_DATA;
        end

        if (stop_det || start_det) begin
            state_d     = stop_det ? IDLE : ADDR;
            bit_cnt_d   = 3'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            phase_d     = 1'b0;
            rx_valid    = 1'b0;
            tx_req      = 1'b0;
            tx_nack     = 1'b0;
            rx_data_d   = rx_data_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oe_d    = 1'b0;
            stretch_d   = 1'b0;
`endif
        end
    end

    assign sda_oe    = sda_oe_q;
    assign addressed = addressed_q;
    assign rx_data   = rx_valid ? byte_in : rx_data_q;

endmodule
